stream_upsizer: RTL and testbench
=================================

Name: stream_upsizer

Overview:
- Ready/valid width converter that packs RATIO consecutive narrow beats of WIDTH bits into one wide word of RATIO*WIDTH bits.
- Sits directly downstream of the backward-registered stage and consumes its s_valid/s_data/s_ready stream.
- Partial words are flushed early on m_last, with a lane-keep mask.
- Output side is fully registered; sustains one narrow beat per cycle when the sink is always ready.

Parameters:
WIDTH, 8, narrow input beat width in bits (>=1)
RATIO, 4, narrow beats per wide word (>=2, power of two not required)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset; one clock; reset is synchronous and active-high
m_valid  input  1  narrow beat valid
m_data  input  WIDTH  narrow beat data
m_last  input  1  final beat of packet; qualified by m_valid
m_ready  output  1  block accepts narrow beat
s_valid  output  1  wide word valid (registered)
s_data  output  RATIO*WIDTH  wide word (registered)
s_keep  output  RATIO  per-lane valid mask (registered)
s_last  output  1  wide word contains packet's final beat (registered)
s_ready  input  1  downstream accepts wide word

Behaviour:
- Transfers: input beat accepted when m_valid & m_ready at the clock edge. Output word consumed when s_valid & s_ready.
- m_ready = ~rst & (~s_valid | s_ready). It is combinational from s_ready and does not depend on m_valid or m_last.
- Internal state:
  - lane counter cnt, 0..RATIO-1, width $clog2(RATIO).
  - assembly register asm_data of (RATIO-1)*WIDTH bits.
  - asm_keep of RATIO-1 bits.
- Lane mapping: beat k of a word goes to lane k, bits [k*WIDTH +: WIDTH]. Lane 0 is the first beat (little-endian).
- Accepted beat with cnt < RATIO-1 and m_last=0:
  - Write lane cnt into asm_data and set asm_keep[cnt].
  - cnt <= cnt+1.
  - Output register unchanged unless drained.
- Completing beat: accepted beat with cnt == RATIO-1, or m_last=1 at any cnt.
  - Output register loads asm_data plus the current beat in lane cnt.
  - s_keep <= asm_keep plus bit cnt set; all lanes above cnt are 0.
  - s_last <= m_last; s_valid <= 1.
  - cnt <= 0; asm_keep cleared.
- Unused lanes above cnt in s_data are zero-filled, never stale.
- Latency: the wide word is visible on s_valid the cycle after its completing beat is accepted.
- Drain: when s_valid & s_ready with no simultaneous completing beat, s_valid <= 0. s_data, s_keep and s_last hold their values but are don't-care.
- Simultaneous drain and completing beat: the output register reloads with the new word and s_valid stays 1. No bubble, no loss.
- Backpressure: while s_valid=1 and s_ready=0, m_ready=0. This stalls even non-completing beats, so the output register is never overwritten. s_* stay stable until consumed.
- m_last on the first beat (cnt=0): emits a single-lane word, s_keep = 1 (lane 0 only).
- RATIO beats exactly with m_last on the final one: s_keep all ones, s_last=1.
- Reset, including mid-word: outputs forced, partial assembly discarded, no word emitted.
  - s_valid=0, s_data=0, s_keep=0, s_last=0.
  - cnt=0, asm_data=0, asm_keep=0.
  - m_ready=0 while rst=1.
- No X on s_data after reset; all registers reset.

Optional Feature:
- Macro STREAM_UPSIZER_BIG_ENDIAN_EN.
- Defined: beat k goes to lane RATIO-1-k, so the first beat lands in the most-significant lane. s_keep bit for beat k is RATIO-1-k. A partial word on m_last is top-aligned, with the zero-filled lanes at the bottom.
- Undefined: little-endian mapping as above.
- Handshake, latency and reset behaviour are identical in both builds.

Test Plan:
1. WIDTH=8, RATIO=4, s_ready=1; beats 0x11,0x22,0x33,0x44 on consecutive cycles, m_last on 0x44 -> one cycle after 0x44: s_data=0x44332211, s_keep=4'b1111, s_last=1; m_ready=1 throughout.
2. Continuous stream of 8 beats 0x01..0x08, s_ready=1, no m_last -> words 0x04030201 then 0x08070605 on cycles 5 and 9 after the first beat. s_last=0, zero input stall.
3. Beats 0xAA,0xBB with m_last on 0xBB -> s_data=0x0000BBAA, s_keep=4'b0011, s_last=1; next beat 0xCC lands in lane 0 of a new word.
4. Word pending with s_ready=0 for 5 cycles -> m_ready=0 and s_data/s_keep/s_last stable for all 5 cycles. Then s_ready=1 with a completing beat on the same cycle -> s_valid remains 1, and the next word loads with no lost or duplicated beat.
5. Feed 0x11,0x22, then assert rst for 1 cycle, then 0x33,0x44,0x55,0x66 -> no word contains 0x11/0x22; first output is 0x66554433. All outputs are 0 and m_ready=0 during rst.
6. Build with STREAM_UPSIZER_BIG_ENDIAN_EN: rerun test 1 -> s_data=0x11223344. Rerun test 3 -> s_data=0xAABB0000, s_keep=4'b1100.

Source files
------------

// File: rtl/stream_upsizer.sv
// rtl/stream_upsizer.sv - packs RATIO narrow beats into one registered wide word; STREAM_UPSIZER_BIG_ENDIAN_EN selects MSB-first lanes
module stream_upsizer #(
    parameter int WIDTH = 8,
    parameter int RATIO = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     m_valid,
    input  logic [WIDTH-1:0]         m_data,
    input  logic                     m_last,
    output logic                     m_ready,
    output logic                     s_valid,
    output logic [RATIO*WIDTH-1:0]   s_data,
    output logic [RATIO-1:0]         s_keep,
    output logic                     s_last,
    input  logic                     s_ready
);

    localparam int CW = $clog2(RATIO);

    // Assembly state: beat k of the word in progress is held in slot k,
    // independent of lane order; lane mapping happens only at output load.
    logic [CW-1:0]                r_cnt;
    logic [(RATIO-1)*WIDTH-1:0]   r_asm_data;
    logic [RATIO-2:0]             r_asm_keep;

    logic                         r_s_valid;
    logic [RATIO*WIDTH-1:0]       r_s_data;
    logic [RATIO-1:0]             r_s_keep;
    logic                         r_s_last;

    logic                         w_ready;
    logic                         w_accept;
    logic                         w_complete;
    logic [RATIO*WIDTH-1:0]       w_word;
    logic [RATIO-1:0]             w_keep;

    // Output lane that receives beat index k of a word.
    function automatic logic [CW-1:0] lane_of(input logic [CW-1:0] k);
`ifdef STREAM_UPSIZER_BIG_ENDIAN_EN
        return CW'(RATIO - 1) - k;
`else
        return k;
`endif
    endfunction

    // Accept whenever the output register is empty or being drained this cycle.
    assign w_ready    = ~rst & (~r_s_valid | s_ready);
    assign w_accept   = m_valid & w_ready;
    assign w_complete = w_accept & (m_last | (r_cnt == CW'(RATIO - 1)));

    // Candidate wide word: assembled beats plus the current beat, unused lanes zero.
    always_comb begin
        w_word = '0;
        w_keep = '0;
        for (int j = 0; j < RATIO - 1; j++) begin
            if (r_asm_keep[j]) begin
                w_word[lane_of(CW'(j))*WIDTH +: WIDTH] = r_asm_data[j*WIDTH +: WIDTH];
                w_keep[lane_of(CW'(j))]                 = 1'b1;
            end
        end
        w_word[lane_of(r_cnt)*WIDTH +: WIDTH] = m_data;
        w_keep[lane_of(r_cnt)]                 = 1'b1;
    end

    // Assembly register and lane counter; a completing beat restarts the word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_asm_data <= '0;
            r_asm_keep <= '0;
        end else if (w_accept) begin
            if (w_complete) begin
                r_cnt      <= '0;
                r_asm_keep <= '0;
            end else begin
                for (int j = 0; j < RATIO - 1; j++) begin
                    if (CW'(j) == r_cnt) begin
                        r_asm_data[j*WIDTH +: WIDTH] <= m_data;
                        r_asm_keep[j]                <= 1'b1;
                    end
                end
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Output register: reload on a completing beat (even while draining), else clear valid on drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s_valid <= 1'b0;
            r_s_data  <= '0;
            r_s_keep  <= '0;
            r_s_last  <= 1'b0;
        end else if (w_complete) begin
            r_s_valid <= 1'b1;
            r_s_data  <= w_word;
            r_s_keep  <= w_keep;
            r_s_last  <= m_last;
        end else if (r_s_valid & s_ready) begin
            r_s_valid <= 1'b0;
        end
    end

    assign m_ready = w_ready;
    assign s_valid = r_s_valid;
    assign s_data  = r_s_data;
    assign s_keep  = r_s_keep;
    assign s_last  = r_s_last;

endmodule

// File: tb/tb_stream_upsizer.sv
// tb/tb_stream_upsizer.sv - directed self-checking bench for stream_upsizer (WIDTH=8, RATIO=4)
module tb_stream_upsizer;

    logic        clk;
    logic        rst;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_last;
    logic        m_ready;
    logic        s_valid;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        s_ready;

    int n_checks;
    int n_errors;

    stream_upsizer #(.WIDTH(8), .RATIO(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_ready (m_ready),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_keep  (s_keep),
        .s_last  (s_last),
        .s_ready (s_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected word from beats in arrival order (b0 first).
    function automatic logic [31:0] pk(input logic [7:0] b0, input logic [7:0] b1,
                                       input logic [7:0] b2, input logic [7:0] b3);
`ifdef STREAM_UPSIZER_BIG_ENDIAN_EN
        return {b0, b1, b2, b3};
`else
        return {b3, b2, b1, b0};
`endif
    endfunction

    // Expected keep from a mask written in arrival order (bit k = beat k present).
    function automatic logic [3:0] kp(input logic [3:0] k);
`ifdef STREAM_UPSIZER_BIG_ENDIAN_EN
        return {k[0], k[1], k[2], k[3]};
`else
        return k;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] d, input logic l);
        m_valid = 1'b1;
        m_data  = d;
        m_last  = l;
    endtask

    task automatic idle();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_last  = 1'b0;
    endtask

    logic [7:0] seq [0:7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        s_ready  = 1'b1;
        idle();

        // Reset state
        step();
        chk("rst_m_ready", {31'd0, m_ready}, 32'd0);
        chk("rst_s_valid", {31'd0, s_valid}, 32'd0);
        chk("rst_s_data",  s_data, 32'd0);
        chk("rst_s_keep",  {28'd0, s_keep}, 32'd0);
        chk("rst_s_last",  {31'd0, s_last}, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_m_ready", {31'd0, m_ready}, 32'd1);

        // Test 1: full packet of four beats, last on the fourth
        seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            drive(seq[i], i == 3);
            #1;
            chk("t1_m_ready", {31'd0, m_ready}, 32'd1);
            step();
            if (i == 2) chk("t1_no_early_valid", {31'd0, s_valid}, 32'd0);
        end
        idle();
        chk("t1_s_valid", {31'd0, s_valid}, 32'd1);
        chk("t1_s_data",  s_data, pk(8'h11, 8'h22, 8'h33, 8'h44));
        chk("t1_s_keep",  {28'd0, s_keep}, {28'd0, kp(4'b1111)});
        chk("t1_s_last",  {31'd0, s_last}, 32'd1);
        step();
        chk("t1_drained", {31'd0, s_valid}, 32'd0);

        // Test 2: eight continuous beats, no m_last
        for (int i = 0; i < 8; i++) begin
            drive(8'(i + 1), 1'b0);
            #1;
            chk("t2_m_ready", {31'd0, m_ready}, 32'd1);
            step();
            if (i == 3) begin
                chk("t2_w0_valid", {31'd0, s_valid}, 32'd1);
                chk("t2_w0_data",  s_data, pk(8'h01, 8'h02, 8'h03, 8'h04));
                chk("t2_w0_last",  {31'd0, s_last}, 32'd0);
            end
            if (i == 4) chk("t2_gap_valid", {31'd0, s_valid}, 32'd0);
        end
        idle();
        chk("t2_w1_valid", {31'd0, s_valid}, 32'd1);
        chk("t2_w1_data",  s_data, pk(8'h05, 8'h06, 8'h07, 8'h08));
        chk("t2_w1_keep",  {28'd0, s_keep}, {28'd0, kp(4'b1111)});
        chk("t2_w1_last",  {31'd0, s_last}, 32'd0);
        step();

        // Test 3: short packet then a single-beat packet
        drive(8'hAA, 1'b0);
        step();
        drive(8'hBB, 1'b1);
        step();
        chk("t3_valid", {31'd0, s_valid}, 32'd1);
        chk("t3_data",  s_data, pk(8'hAA, 8'hBB, 8'h00, 8'h00));
        chk("t3_keep",  {28'd0, s_keep}, {28'd0, kp(4'b0011)});
        chk("t3_last",  {31'd0, s_last}, 32'd1);
        drive(8'hCC, 1'b1);
        step();
        idle();
        chk("t3_cc_valid", {31'd0, s_valid}, 32'd1);
        chk("t3_cc_data",  s_data, pk(8'hCC, 8'h00, 8'h00, 8'h00));
        chk("t3_cc_keep",  {28'd0, s_keep}, {28'd0, kp(4'b0001)});
        step();
        chk("t3_drained", {31'd0, s_valid}, 32'd0);

        // Test 4: backpressure for five cycles, then drain with a simultaneous completing beat
        s_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(8'(i + 1), 1'b0);
            step();
        end
        drive(8'h05, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_m_ready", {31'd0, m_ready}, 32'd0);
            chk("t4_stall_valid",   {31'd0, s_valid}, 32'd1);
            chk("t4_stall_data",    s_data, pk(8'h01, 8'h02, 8'h03, 8'h04));
            chk("t4_stall_keep",    {28'd0, s_keep}, {28'd0, kp(4'b1111)});
            chk("t4_stall_last",    {31'd0, s_last}, 32'd0);
            step();
        end
        s_ready = 1'b1;
        #1;
        chk("t4_release_m_ready", {31'd0, m_ready}, 32'd1);
        step();
        chk("t4_b_valid", {31'd0, s_valid}, 32'd1);
        chk("t4_b_data",  s_data, pk(8'h05, 8'h00, 8'h00, 8'h00));
        chk("t4_b_keep",  {28'd0, s_keep}, {28'd0, kp(4'b0001)});
        chk("t4_b_last",  {31'd0, s_last}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            drive(8'(i + 6), 1'b0);
            step();
            if (i == 0) chk("t4_b_drained", {31'd0, s_valid}, 32'd0);
        end
        idle();
        chk("t4_c_valid", {31'd0, s_valid}, 32'd1);
        chk("t4_c_data",  s_data, pk(8'h06, 8'h07, 8'h08, 8'h09));

        // Test 5: reset mid-word discards the partial assembly
        drive(8'h11, 1'b0);
        step();
        drive(8'h22, 1'b0);
        step();
        idle();
        rst = 1'b1;
        #1;
        chk("t5_rst_m_ready_comb", {31'd0, m_ready}, 32'd0);
        step();
        chk("t5_rst_valid",   {31'd0, s_valid}, 32'd0);
        chk("t5_rst_data",    s_data, 32'd0);
        chk("t5_rst_keep",    {28'd0, s_keep}, 32'd0);
        chk("t5_rst_last",    {31'd0, s_last}, 32'd0);
        chk("t5_rst_m_ready", {31'd0, m_ready}, 32'd0);
        rst = 1'b0;
        seq[0] = 8'h33; seq[1] = 8'h44; seq[2] = 8'h55; seq[3] = 8'h66;
        for (int i = 0; i < 4; i++) begin
            drive(seq[i], 1'b0);
            step();
            if (i < 3) chk("t5_no_stale_word", {31'd0, s_valid}, 32'd0);
        end
        idle();
        chk("t5_valid", {31'd0, s_valid}, 32'd1);
        chk("t5_data",  s_data, pk(8'h33, 8'h44, 8'h55, 8'h66));
        chk("t5_keep",  {28'd0, s_keep}, {28'd0, kp(4'b1111)});
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
